// File: rtl/fir_stage2_if.sv
// Sample-stream bundle between the upstream stage and fir_stage2.
// master drives samples in; slave is the interpolator.
interface fir_stage2_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic signed [DW-1:0] data_in;
    logic                 out_valid;
    logic signed [DW-1:0] data_out;
    logic                 busy;
    logic                 overrun;

    modport master (output in_valid, data_in, input out_valid, data_out, busy, overrun);
    modport slave  (input in_valid, data_in, output out_valid, data_out, busy, overrun);
endinterface

// File: rtl/fir_stage2.sv
// x2 half-band polyphase interpolator: phase 0 is a symmetric FIR evaluated one coefficient
// pair per cycle on a shared pre-add/MAC; phase 1 is the delayed centre tap.
module fir_stage2 #(
    parameter int DW       = 16,
    parameter int CW       = 16,
    parameter int NPAIR    = 6,
    parameter int HALF_GAP = 8,
    // Packed c[NPAIR-1]..c[0], signed Q1.15 (the hb2_coef.hex set); c[k] weights x[k] + x[2*NPAIR-1-k]
    parameter logic [NPAIR*CW-1:0] COEF = 96'h4E88_EA20_0AF0_FAEC_0212_FF6A
) (
    input  logic        clk,
    input  logic        rst_n,
    fir_stage2_if.slave bus
);
    localparam int NTAP = 2 * NPAIR;
    localparam int IW   = $clog2(NTAP);
    localparam int KW   = $clog2(NPAIR);
    localparam int GW   = $clog2(HALF_GAP);
    localparam int PW   = DW + 1;
    localparam int MW   = PW + CW;
    localparam int AW   = MW + 3;
    localparam logic signed [AW-1:0] RHALF = AW'(2 ** (CW - 2));
    localparam logic signed [AW-1:0] YMAX  = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] YMIN  = -YMAX - 1;

    typedef enum logic [2:0] {IDLE, MAC, RND, WAIT, OUT1, TAIL} state_t;

    state_t state, state_nx;
    logic accept, mac_step, emit0, emit1;

    logic signed [DW-1:0] x [NTAP];
    logic signed [CW-1:0] ctab [NPAIR];
    logic [KW-1:0]        k;
    logic [GW-1:0]        gcnt;
    logic signed [AW-1:0] acc;
    logic                 out_valid_q, overrun_q;
    logic signed [DW-1:0] data_out_q;

    logic [IW-1:0]        ka, kb;
    logic signed [PW-1:0] pair;
    logic signed [CW-1:0] ck;
    logic signed [MW-1:0] prod;
    logic signed [AW-1:0] rsum, rshift;
    logic signed [DW-1:0] y0;

    for (genvar g = 0; g < NPAIR; g++) begin : g_coef
        assign ctab[g] = COEF[g*CW +: CW];
    end

    // Step k folds the two taps sharing c[k] before the multiply.
    assign ka   = IW'(k);
    assign kb   = IW'(NTAP - 1) - ka;
    assign pair = PW'(x[ka]) + PW'(x[kb]);
    assign ck   = ctab[k];
    assign prod = pair * ck;

    assign rsum   = acc + RHALF;
    assign rshift = rsum >>> (CW - 1);

    always_comb begin
        if (rshift > YMAX)      y0 = YMAX[DW-1:0];
        else if (rshift < YMIN) y0 = YMIN[DW-1:0];
        else                    y0 = rshift[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        mac_step = 1'b0;
        emit0    = 1'b0;
        emit1    = 1'b0;
        unique case (state)
            IDLE: if (bus.in_valid) begin
                accept   = 1'b1;
                state_nx = MAC;
            end
            MAC: begin
                mac_step = 1'b1;
                if (k == KW'(NPAIR - 1)) state_nx = RND;
            end
            RND: begin
                emit0    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (gcnt == GW'(HALF_GAP - 2)) state_nx = OUT1;
            OUT1: begin
                emit1    = 1'b1;
                state_nx = TAIL;
            end
            // Holds busy for the cycle after the phase-1 strobe.
            TAIL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) x[i] <= '0;
            acc         <= '0;
            k           <= '0;
            gcnt        <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept) begin
                x[0] <= bus.data_in;
                for (int i = 1; i < NTAP; i++) x[i] <= x[i-1];
                k <= '0;
            end
            if (mac_step) begin
                acc <= (k == '0) ? AW'(prod) : acc + AW'(prod);
                k   <= k + 1'b1;
            end
            if (state == RND)       gcnt <= '0;
            else if (state == WAIT) gcnt <= gcnt + 1'b1;
            if (emit0) begin
                data_out_q  <= y0;
                out_valid_q <= 1'b1;
            end
            if (emit1) begin
                data_out_q  <= x[NPAIR-1];
                out_valid_q <= 1'b1;
            end
            if (bus.in_valid && state != IDLE) overrun_q <= 1'b1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.busy      = (state != IDLE);
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_fir_stage2.sv
// Bench for fir_stage2: impulse vector table, DC, saturation, overrun and mid-sequence reset,
// with a tap-by-tap reference model feeding an expected-output queue.
module tb_fir_stage2;
    localparam int C [6] = '{-150, 530, -1300, 2800, -5600, 20104};

    typedef struct {int din; int ph0; int ph1;} vec_t;
    typedef struct {int val; int cyc; bit ph;} exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fir_stage2_if #(.DW(16)) bus ();
    fir_stage2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0, failures = 0;
    int   cyc = 0, nstrobe = 0, last_ph0 = 0;
    int   mx [12];
    exp_t exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Direct-form reference over all 12 taps with mirrored coefficients.
    function automatic int model_y0();
        longint acc = 0;
        for (int j = 0; j < 12; j++) acc += longint'(mx[j]) * C[(j < 6) ? j : 11 - j];
        acc = (acc + 16384) >>> 15;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            exp_t e;
            nstrobe++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got data %0d, expected no strobe (cycle %0d)",
                         int'(bus.data_out), cyc);
            end else begin
                e = exp_q.pop_front();
                chk(e.ph ? "ph1_data" : "ph0_data", int'(bus.data_out), e.val);
                chk("strobe_cycle", cyc, e.cyc);
                if (!e.ph) last_ph0 = int'(bus.data_out);
            end
        end
    end

    // Pulses in_valid for one cycle; returns one tick after the acceptance edge.
    task automatic send(input int v, input bit use_tbl, input int e0, input int e1);
        int t0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.data_in  = 16'(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        t0 = cyc;
        for (int j = 11; j > 0; j--) mx[j] = mx[j-1];
        mx[0] = v;
        if (use_tbl) begin
            exp_q.push_back('{e0, t0 + 7, 1'b0});
            exp_q.push_back('{e1, t0 + 15, 1'b1});
        end else begin
            exp_q.push_back('{model_y0(), t0 + 7, 1'b0});
            exp_q.push_back('{mx[5], t0 + 15, 1'b1});
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [13];
        int   bad, ns0, ci, v;

        tbl[0]  = '{16384, -75, 0};
        tbl[1]  = '{0, 265, 0};
        tbl[2]  = '{0, -650, 0};
        tbl[3]  = '{0, 1400, 0};
        tbl[4]  = '{0, -2800, 0};
        tbl[5]  = '{0, 10052, 16384};
        tbl[6]  = '{0, 10052, 0};
        tbl[7]  = '{0, -2800, 0};
        tbl[8]  = '{0, 1400, 0};
        tbl[9]  = '{0, -650, 0};
        tbl[10] = '{0, 265, 0};
        tbl[11] = '{0, -75, 0};
        tbl[12] = '{0, 0, 0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.data_out !== 16'sd0 ||
                bus.busy !== 1'b0 || bus.overrun !== 1'b0) bad++;
        end
        chk("idle_quiet_cycles_bad", bad, 0);

        // Impulse response through both phases, one sample per 20 cycles
        for (int i = 0; i < 13; i++) begin
            send(tbl[i].din, 1'b1, tbl[i].ph0, tbl[i].ph1);
            gap(18);
        end

        // DC; the first sample also checks busy framing
        ns0 = nstrobe;
        send(1000, 1'b0, 0, 0);
        chk("busy_after_accept", int'(bus.busy), 1);
        gap(15); #1;
        chk("busy_at_ph1_strobe", int'(bus.busy), 1);
        @(posedge clk); #1;
        chk("busy_dropped", int'(bus.busy), 0);
        for (int i = 1; i < 30; i++) begin
            send(1000, 1'b0, 0, 0);
            gap(15);
        end
        gap(4);
        chk("dc_strobe_count", nstrobe - ns0, 60);
        chk("dc_settled_ph0", last_ph0, 1000);

        // Worst-case sign pattern in both polarities
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 12; i++) begin
                ci = (11 - i < 6) ? 11 - i : i;
                v  = (C[ci] > 0) ? 32767 : -32767;
                send(s == 0 ? v : -v, 1'b0, 0, 0);
                gap(15);
            end
            gap(4);
            chk(s == 0 ? "sat_pos" : "sat_neg", last_ph0, s == 0 ? 32767 : -32768);
        end

        // Overrun: second strobe 5 cycles after acceptance is ignored
        ns0 = nstrobe;
        send(300, 1'b0, 0, 0);
        gap(4); #1;
        chk("overrun_before", int'(bus.overrun), 0);
        bus.in_valid = 1'b1;
        bus.data_in  = -16'sd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("overrun_set", int'(bus.overrun), 1);
        gap(16);
        chk("overrun_strobes", nstrobe - ns0, 2);
        send(-1234, 1'b0, 0, 0);
        gap(15);
        chk("overrun_sticky", int'(bus.overrun), 1);

        // Reset three cycles into a sequence
        send(500, 1'b0, 0, 0);
        gap(3); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int j = 0; j < 12; j++) mx[j] = 0;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_overrun", int'(bus.overrun), 0);
        chk("midrst_data_out", int'(bus.data_out), 0);
        ns0 = nstrobe;
        gap(20);
        chk("midrst_no_strobe", nstrobe - ns0, 0);
        send(100, 1'b0, 0, 0);
        gap(15);
        send(-20000, 1'b0, 0, 0);
        gap(20);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
